// File: rtl/pusch_pingpong_ctrl.sv
// Ping-pong bank controller between the PUSCH modulation mapper (writer)
// and the transform-precoding FFT (reader). Tracks which bank each side
// owns, whether each bank holds a complete symbol, issues FFT read bursts
// and counts symbols per slot. One instance serves both the real and the
// imaginary sample memories.
module pusch_pingpong_ctrl #(
  parameter int unsigned MEM_DEPTH    = 1200,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned SYM_PER_SLOT = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  wr_done,
  input  logic [ADDR_WIDTH-1:0] wr_len,
  input  logic                  rd_ready,
  input  logic                  rd_finish,
  output logic                  wr_bank,
  output logic                  wr_allow,
  output logic                  rd_bank,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_start,
  output logic                  rd_last,
  output logic [1:0]            bank_full,
  output logic [3:0]            sym_count,
  output logic                  slot_done,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;

  // Stored symbol length per bank, already clamped to MEM_DEPTH.
  logic [ADDR_WIDTH-1:0] len_q [0:1];
  logic [ADDR_WIDTH-1:0] len_sel;
  logic [ADDR_WIDTH-1:0] len_clamped;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] last_addr;

  logic                  wr_accept;
  logic                  wr_reject;
  logic                  release_bank;
  logic                  burst_go;
  logic                  sym_wrap;

  logic                  rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic                  rd_start_d;
  logic                  rd_last_d;
  logic [1:0]            bank_full_d;

  // Mapper may write whenever the bank it currently points at is empty.
  assign wr_allow     = enable & ~bank_full[wr_bank];

  // A zero-length symbol is never a valid fill; it is flagged like a
  // rejected write rather than marking an empty bank as full.
  assign wr_accept    = wr_done & wr_allow & (wr_len != '0);
  assign wr_reject    = wr_done & ~wr_accept;

  // Release only happens from DRAIN; rd_finish elsewhere is ignored.
  assign release_bank = (state_q == ST_DRAIN) & rd_finish;

  assign burst_go     = enable & rd_ready & bank_full[rd_bank];
  assign sym_wrap     = (sym_count == 4'(SYM_PER_SLOT - 1));

  assign len_sel      = len_q[rd_bank];
  assign addr_inc     = rd_addr + ADDR_WIDTH'(1);
  assign last_addr    = len_sel - ADDR_WIDTH'(1);

  // Clamp oversize symbols to the bank depth. The clamp branch is only
  // taken when MEM_DEPTH is representable in ADDR_WIDTH bits.
  always_comb begin
    len_clamped = wr_len;
    if (32'(wr_len) > MEM_DEPTH) begin
      len_clamped = ADDR_WIDTH'(MEM_DEPTH);
    end
  end

  // Next-state and next-beat logic for the read burst FSM.
  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = '0;
    rd_start_d = 1'b0;
    rd_last_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (burst_go) begin
          state_d    = ST_STREAM;
          rd_en_d    = 1'b1;
          rd_start_d = 1'b1;
          rd_last_d  = (len_sel == ADDR_WIDTH'(1));
        end
      end
      ST_STREAM: begin
        // rd_last marks the beat currently on the outputs; once it has
        // been presented the burst is over and the bank waits for the FFT.
        if (rd_last) begin
          state_d = ST_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_inc;
          rd_last_d = (addr_inc == last_addr);
        end
      end
      ST_DRAIN: begin
        if (rd_finish) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Full-flag update: a write fill and a read release can land in the
  // same cycle; they always refer to different banks because the write
  // bank must be empty and the read bank must be full.
  always_comb begin
    bank_full_d = bank_full;
    if (wr_accept) begin
      bank_full_d[wr_bank] = 1'b1;
    end
    if (release_bank) begin
      bank_full_d[rd_bank] = 1'b0;
    end
  end

  // FSM state register and registered read-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      rd_start <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_en    <= rd_en_d;
      rd_addr  <= rd_addr_d;
      rd_start <= rd_start_d;
      rd_last  <= rd_last_d;
    end
  end

  // Bank ownership, fill flags, stored lengths and the sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      overflow  <= 1'b0;
    end else begin
      bank_full <= bank_full_d;
      if (wr_accept) begin
        len_q[wr_bank] <= len_clamped;
        wr_bank        <= ~wr_bank;
      end
      if (release_bank) begin
        rd_bank <= ~rd_bank;
      end
      if (wr_reject) begin
        overflow <= 1'b1;
      end
    end
  end

  // Per-slot symbol counter with a one-cycle slot_done on wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_count <= '0;
      slot_done <= 1'b0;
    end else begin
      slot_done <= 1'b0;
      if (release_bank) begin
        if (sym_wrap) begin
          sym_count <= '0;
          slot_done <= 1'b1;
        end else begin
          sym_count <= sym_count + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pusch_pingpong_ctrl.sv
// Self-checking bench for pusch_pingpong_ctrl: directed scenarios with
// literal expectations plus a randomized run, all outputs compared every
// cycle against a queue-based reference model.
module tb_pusch_pingpong_ctrl;

  localparam int DEPTH = 1200;
  localparam int AW    = 11;
  localparam int SPS   = 12;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          enable    = 1'b0;
  logic          wr_done   = 1'b0;
  logic [AW-1:0] wr_len    = '0;
  logic          rd_ready  = 1'b0;
  logic          rd_finish = 1'b0;

  logic          wr_bank;
  logic          wr_allow;
  logic          rd_bank;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_start;
  logic          rd_last;
  logic [1:0]    bank_full;
  logic [3:0]    sym_count;
  logic          slot_done;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  pusch_pingpong_ctrl #(
    .MEM_DEPTH   (DEPTH),
    .ADDR_WIDTH  (AW),
    .SYM_PER_SLOT(SPS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .wr_done  (wr_done),
    .wr_len   (wr_len),
    .rd_ready (rd_ready),
    .rd_finish(rd_finish),
    .wr_bank  (wr_bank),
    .wr_allow (wr_allow),
    .rd_bank  (rd_bank),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_start (rd_start),
    .rd_last  (rd_last),
    .bank_full(bank_full),
    .sym_count(sym_count),
    .slot_done(slot_done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending complete symbols in write order; q[0] is the bank being read.
  int q[$];
  bit m_rb;
  int m_beat  = -1;   // current beat index of the burst, -1 when none
  bit m_drain;
  int m_sym;
  bit m_slot;
  bit m_ovf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_rb    = 1'b0;
      m_beat  = -1;
      m_drain = 1'b0;
      m_sym   = 0;
      m_slot  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      bit rel;
      bit acc;
      int l;
      rel = m_drain && rd_finish;
      acc = wr_done && enable && (q.size() < 2) && (wr_len != 0);
      if (wr_done && !acc) m_ovf = 1'b1;
      m_slot = 1'b0;
      if (m_beat >= 0) begin
        if (m_beat == q[0] - 1) begin
          m_beat  = -1;
          m_drain = 1'b1;
        end else begin
          m_beat++;
        end
      end else if (!m_drain && enable && rd_ready && q.size() > 0) begin
        m_beat = 0;
      end
      if (rel) begin
        void'(q.pop_front());
        m_rb    = !m_rb;
        m_drain = 1'b0;
        m_sym++;
        if (m_sym == SPS) begin
          m_sym  = 0;
          m_slot = 1'b1;
        end
      end
      if (acc) begin
        l = int'(wr_len);
        if (l > DEPTH) l = DEPTH;
        q.push_back(l);
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    logic [1:0] ef;
    bit ewb;
    ef = 2'b00;
    if (q.size() >= 1) ef[m_rb]  = 1'b1;
    if (q.size() == 2) ef[!m_rb] = 1'b1;
    ewb = m_rb ^ (q.size() == 1);
    chk("m_bank_full", 32'(bank_full), 32'(ef));
    chk("m_wr_bank",   32'(wr_bank),   32'(ewb));
    chk("m_rd_bank",   32'(rd_bank),   32'(m_rb));
    chk("m_wr_allow",  32'(wr_allow),  32'(enable && q.size() < 2));
    chk("m_rd_en",     32'(rd_en),     32'(m_beat >= 0));
    chk("m_rd_addr",   32'(rd_addr),   32'((m_beat >= 0) ? m_beat : 0));
    chk("m_rd_start",  32'(rd_start),  32'(m_beat == 0));
    chk("m_rd_last",   32'(rd_last),   32'((m_beat >= 0) && (m_beat == q[0] - 1)));
    chk("m_sym_count", 32'(sym_count), 32'(m_sym));
    chk("m_slot_done", 32'(slot_done), 32'(m_slot));
    chk("m_overflow",  32'(overflow),  32'(m_ovf));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wr(input int len);
    wr_done = 1'b1;
    wr_len  = AW'(len);
    tick();
    wr_done = 1'b0;
  endtask

  task automatic fin();
    rd_finish = 1'b1;
    tick();
    rd_finish = 1'b0;
  endtask

  task automatic run_burst(input string nm, input int exp_len, input int exp_bank);
    int cyc       = 0;
    int beats     = 0;
    int addr_err  = 0;
    int starts    = 0;
    int lasts     = 0;
    int last_addr = -1;
    while (!rd_en && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!rd_en) begin
      chk({nm, "_timeout"}, 32'(0), 32'(1));
      return;
    end
    chk({nm, "_bank"}, 32'(rd_bank), 32'(exp_bank));
    while (rd_en && beats < 2000) begin
      if (int'(rd_addr) != beats) addr_err++;
      if (rd_start) begin
        starts++;
        if (beats != 0) addr_err++;
      end
      if (rd_last) begin
        lasts++;
        last_addr = int'(rd_addr);
      end
      beats++;
      tick();
    end
    chk({nm, "_beats"},     32'(beats),     32'(exp_len));
    chk({nm, "_starts"},    32'(starts),    32'(1));
    chk({nm, "_lasts"},     32'(lasts),     32'(1));
    chk({nm, "_last_addr"}, 32'(last_addr), 32'(exp_len - 1));
    chk({nm, "_addr_seq"},  32'(addr_err),  32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b1;
    tick();
    tick();
    // reset state
    chk("rst_rd_en",     32'(rd_en),     32'(0));
    chk("rst_bank_full", 32'(bank_full), 32'(0));
    chk("rst_wr_bank",   32'(wr_bank),   32'(0));
    chk("rst_sym",       32'(sym_count), 32'(0));
    chk("rst_overflow",  32'(overflow),  32'(0));
    reset = 1'b1;
    tick();

    // basic 12-sample symbol
    rd_ready = 1'b1;
    wr(12);
    chk("s1_full", 32'(bank_full), 32'(2'b01));
    chk("s1_wrb",  32'(wr_bank),   32'(1));
    run_burst("s1", 12, 0);
    fin();
    chk("s1_rel_full", 32'(bank_full), 32'(2'b00));
    chk("s1_rel_rdb",  32'(rd_bank),   32'(1));
    chk("s1_sym",      32'(sym_count), 32'(1));

    // both banks full, third write rejected
    do_reset();
    rd_ready = 1'b0;
    wr(24);
    wr(36);
    chk("s2_full",  32'(bank_full), 32'(2'b11));
    chk("s2_allow", 32'(wr_allow),  32'(0));
    wr(5);
    chk("s2_ovf",   32'(overflow),  32'(1));
    chk("s2_full2", 32'(bank_full), 32'(2'b11));
    rd_ready = 1'b1;
    run_burst("s2a", 24, 0);
    fin();
    run_burst("s2b", 36, 1);
    fin();

    // clamping and zero length
    do_reset();
    wr(1500);
    run_burst("s3", 1200, 0);
    fin();
    chk("s3_ovf0", 32'(overflow), 32'(0));
    wr(0);
    chk("s3_ovf",  32'(overflow),  32'(1));
    chk("s3_full", 32'(bank_full), 32'(0));

    // full slot of symbols
    do_reset();
    for (int i = 0; i < SPS; i++) begin
      wr(3);
      run_burst("s4", 3, i % 2);
      fin();
      chk("s4_sym",  32'(sym_count), 32'((i + 1) % SPS));
      chk("s4_slot", 32'(slot_done), 32'(i == SPS - 1));
    end
    tick();
    chk("s4_slot_clr", 32'(slot_done), 32'(0));

    // reset in the middle of a burst
    do_reset();
    wr(12);
    begin
      int cyc = 0;
      while (!(rd_en && rd_addr == AW'(5)) && cyc < 50) begin
        tick();
        cyc++;
      end
      chk("s5_reached", 32'(rd_addr), 32'(5));
    end
    reset = 1'b0;
    #1;
    chk("s5_rd_en", 32'(rd_en),     32'(0));
    chk("s5_full",  32'(bank_full), 32'(0));
    tick();
    reset = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (rd_en) seen++;
      end
      chk("s5_no_burst", 32'(seen), 32'(0));
    end

    // write to bank 1 coinciding with release of bank 0
    do_reset();
    wr(4);
    run_burst("s6a", 4, 0);
    wr_done   = 1'b1;
    wr_len    = AW'(7);
    rd_finish = 1'b1;
    tick();
    wr_done   = 1'b0;
    rd_finish = 1'b0;
    chk("s6_full", 32'(bank_full), 32'(2'b10));
    chk("s6_wrb",  32'(wr_bank),   32'(0));
    chk("s6_rdb",  32'(rd_bank),   32'(1));
    chk("s6_ovf",  32'(overflow),  32'(0));
    run_burst("s6b", 7, 1);
    fin();

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset     = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      enable    = ($urandom_range(0, 9) != 0);
      rd_ready  = ($urandom_range(0, 9) < 7);
      wr_done   = ($urandom_range(0, 4) == 0);
      rd_finish = ($urandom_range(0, 9) < 3);
      r = $urandom_range(0, 99);
      if (r < 5)      wr_len = '0;
      else if (r < 7) wr_len = AW'(1500);
      else            wr_len = AW'($urandom_range(1, 16));
      tick();
    end
    reset     = 1'b1;
    wr_done   = 1'b0;
    rd_finish = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
